pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- The NBIT operand is split into PIPE equal segments; each segment is added in its own register stage using GRP-bit lookahead groups, and the carry ripples stage to stage.
- Adds a subtract mode, signed-overflow flag, backpressure and bubble-collapsing flow control; serves as the datapath adder for multi-cycle arithmetic blocks.

Parameters:
- NBIT, 12, operand/result width; must satisfy NBIT % PIPE == 0.
- PIPE, 3, number of pipeline stages, i.e. latency in cycles; range 1..NBIT.
- GRP, 4, lookahead group width inside a segment; a last partial group is allowed when SEG % GRP != 0.
- SEG, NBIT/PIPE, derived segment width; local, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a/b/cin/sub valid.
- in_ready  out  1  pipeline accepts the operand this cycle.
- a  in  NBIT  operand A.
- b  in  NBIT  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result this cycle.
- s  out  NBIT  sum/difference.
- cout  out  1  carry-out (add) or not-borrow (sub).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n).
- Arithmetic:
  - sub=0: {cout,s} = a + b + cin.
  - sub=1: {cout,s} = a + ~b + !cin, which gives a - b - cin; cout=1 means no borrow.
  - ovf = carry into bit NBIT-1 XOR cout.
  - All results are exact modulo 2^NBIT.
- Operand conditioning: b is XORed with sub and the carry-in is (cin XOR sub) at stage-0 input, combinationally before the first register.
- Stage k (0..PIPE-1):
  - Adds segment k (bits k*SEG .. k*SEG+SEG-1) using the incoming carry from stage k-1 (or the conditioned cin at k=0).
  - Within a segment, carries are computed by GRP-bit generate/propagate lookahead, with group carries rippling between groups.
  - Registers the segment sum, carry-out, carry into the segment MSB, the already-computed lower sum bits, and the not-yet-added upper a/b bits (skew registers).
- Latency: exactly PIPE cycles from an accepted input to out_valid when out_ready is held high. Throughput is 1 result/cycle.
- Flow control, per stage valid bit v[k]:
  - adv[PIPE-1] = v[PIPE-1] & out_ready.
  - adv[k] = v[k] & (!v[k+1] | adv[k+1]).
  - in_ready = !v[0] | adv[0], which is combinational from out_ready.
  - Stage k loads only when it is empty or advancing; otherwise it holds. Bubbles collapse.
- Outputs:
  - out_valid = v[PIPE-1].
  - s/cout/ovf come from the last stage registers.
  - While out_valid & !out_ready, s/cout/ovf hold stable.
- Simultaneous accept and drain with a full pipe: no loss, no duplication, order preserved.
- Reset (any time, including mid-operation):
  - All v[k]=0, out_valid=0, s=0, cout=0, ovf=0, all skew/data registers 0.
  - In-flight operations are discarded.
  - in_ready=1 in the first cycle after rst_n rises.
- PIPE=1: the block degenerates to a single registered full-width CLA.
- Inputs are sampled only when in_valid & in_ready; a/b/cin/sub are don't-care otherwise.

Decomposition:
- Shared package: ADD/SUB mode encoding, default NBIT/PIPE/GRP constants, and an elaboration-time check function that NBIT % PIPE == 0.
- One sub-module, cla_segment (combinational):
  - Parameters W, GRP.
  - Inputs: a, b, ci.
  - Outputs: s, co, c_msb (carry into bit W-1).
  - Instantiated PIPE times.
- The top level holds skew registers, valid bits and flow control.

Test Plan:
- a=0x0FF, b=0x001, cin=0, sub=0 -> after 3 cycles s=0x100, cout=0, ovf=0 (carry crosses both segment boundaries).
- a=0xFFF, b=0x001, add -> s=0x000, cout=1, ovf=0. Then a=0x7FF, b=0x001 -> s=0x800, cout=0, ovf=1.
- sub=1, a=0x005, b=0x007, cin=0 -> s=0xFFE, cout=0, ovf=0. Then a=0x800, b=0x001, cin=0 -> s=0x7FF, cout=1, ovf=1.
- Stream 8 back-to-back ops with out_ready=0 for cycles 4..7:
  - in_ready drops once 3 ops are held.
  - Outputs hold stable while stalled.
  - All 8 results emerge in order, none lost or duplicated.
- Assert rst_n low for 1 cycle with 2 ops in flight -> out_valid=0 immediately (async), s=0; no stale result appears afterwards.
- Random constrained regression (PIPE=1,2,3,4,6; GRP=3,4; random stalls) against a reference model of {cout,s} and ovf.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// Holds the add/subtract mode encoding, default geometry and a geometry check.
// No logic; imported by the adder top level.
package pipelined_cla_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int DEF_NBIT = 12;
    localparam int DEF_PIPE = 3;
    localparam int DEF_GRP  = 4;

    // Operand must split into PIPE equal, non-empty segments.
    function automatic bit nbit_pipe_ok(input int nbit, input int pipe);
        return (pipe >= 1) && (pipe <= nbit) && ((nbit % pipe) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_segment.sv
// Purpose: combinational W-bit adder slice built from GRP-bit lookahead groups.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing pipeline stage decides when to capture.
module cla_segment #(
    parameter int W   = 4,
    parameter int GRP = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         cc;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each bit's carry is a flat generate/propagate sum of products back to the
    // start of its group; only the group carry-in ripples between groups.
    always_comb begin
        c    = '0;
        cc   = 1'b0;
        pp   = 1'b1;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            int lo;
            lo = (i / GRP) * GRP;
            cc = 1'b0;
            pp = 1'b1;
            for (int m = i; m >= lo; m--) begin
                cc = cc | (pp & g[m]);
                pp = pp & p[m];
            end
            c[i+1] = cc | (pp & c[lo]);
        end
    end

    assign s     = p ^ c[W-1:0];
    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Purpose: pipelined CLA adder/subtractor, one operand segment added per stage.
// Latency: PIPE cycles from accept to out_valid; one result per cycle sustained.
// Backpressure: a stage holds unless empty or draining; in_ready follows out_ready combinationally.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int NBIT = DEF_NBIT,
    parameter int PIPE = DEF_PIPE,
    parameter int GRP  = DEF_GRP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] s,
    output logic            cout,
    output logic            ovf
);

    localparam int SEG = NBIT / PIPE;

    if (!nbit_pipe_ok(NBIT, PIPE)) begin : g_param_check
        $error("pipelined_cla_adder: NBIT must be a multiple of PIPE");
    end

    // acc: finished sum bits below the current segment, raw a bits above it.
    // bop: conditioned b bits not yet consumed (consumed bits are cleared).
    // co : carry leaving the most recently added segment.
    // cm : carry into the MSB of the most recently added segment.
    typedef struct packed {
        logic [NBIT-1:0] acc;
        logic [NBIT-1:0] bop;
        logic            co;
        logic            cm;
    } stage_t;

    stage_t          stage_in [PIPE];
    stage_t          stage_d  [PIPE];
    stage_t          stage_q  [PIPE];
    logic [PIPE-1:0] v;
    logic [PIPE-1:0] ld;
    logic [PIPE-1:0] src_vld;
    logic            go_chain;
    logic            sub_en;

    assign sub_en = (mode_e'(sub) == MODE_SUB);

    // Subtraction is a + ~b + 1 with the borrow-in folded into the carry-in.
    assign stage_in[0] = '{acc: a,
                           bop: b ^ {NBIT{sub_en}},
                           co:  cin ^ sub_en,
                           cm:  1'b0};

    // Walk from the output back to the input: a stage may load when it is
    // empty or when everything ahead of it is able to move this cycle.
    always_comb begin
        ld       = '0;
        src_vld  = '0;
        go_chain = out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            ld[k]    = !v[k] | go_chain;
            go_chain = ld[k];
        end
        in_ready   = go_chain;
        src_vld[0] = in_valid;
        for (int k = 1; k < PIPE; k++) begin
            src_vld[k] = v[k-1];
        end
    end

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        logic [SEG-1:0] seg_s;
        logic           seg_co;
        logic           seg_cm;
        stage_t         nxt;

        if (k > 0) begin : g_link
            assign stage_in[k] = stage_q[k-1];
        end

        cla_segment #(
            .W   (SEG),
            .GRP (GRP)
        ) u_seg (
            .a     (stage_in[k].acc[k*SEG +: SEG]),
            .b     (stage_in[k].bop[k*SEG +: SEG]),
            .ci    (stage_in[k].co),
            .s     (seg_s),
            .co    (seg_co),
            .c_msb (seg_cm)
        );

        // Splice this segment's sum into the skewed word and retire its b bits.
        always_comb begin
            nxt                   = stage_in[k];
            nxt.acc[k*SEG +: SEG] = seg_s;
            nxt.bop[k*SEG +: SEG] = '0;
            nxt.co                = seg_co;
            nxt.cm                = seg_cm;
        end

        assign stage_d[k] = nxt;
    end

    // Valid bits and stage data advance together; data only captured when a
    // real operation arrives so an idle output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < PIPE; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (ld[k]) begin
                    v[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        stage_q[k] <= stage_d[k];
                    end
                end
            end
        end
    end

    assign out_valid = v[PIPE-1];
    assign s         = stage_q[PIPE-1].acc;
    assign cout      = stage_q[PIPE-1].co;
    assign ovf       = stage_q[PIPE-1].co ^ stage_q[PIPE-1].cm;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (NBIT=12, PIPE=3, GRP=4).
// Latency, stall/ordering, async reset and a short randomised stream.
// Results compared against hand-computed constants or an arithmetic model.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] s;
    logic        cout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .NBIT (12),
        .PIPE (3),
        .GRP  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic; overflow from the true signed result.
    function automatic logic [13:0] ref_model(input logic [11:0] x, input logic [11:0] y,
                                              input logic ci, input logic sb);
        int          sx;
        int          sy;
        int          t;
        logic [12:0] full;
        logic        ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            t    = sx - sy - int'(ci);
            full = {1'b0, x} + {1'b0, ~y} + {12'b0, ~ci};
        end else begin
            t    = sx + sy + int'(ci);
            full = {1'b0, x} + {1'b0, y} + {12'b0, ci};
        end
        ov = (t > 2047) || (t < -2048);
        return {full[12], ov, full[11:0]};
    endfunction

    // Single operation on an idle pipe with out_ready high.
    task automatic run_op(input string tag, input logic [11:0] av, input logic [11:0] bv,
                          input logic cv, input logic sv, input logic [11:0] es,
                          input logic ec, input logic eo);
        int lat;
        in_valid = 1'b1; a = av; b = bv; cin = cv; sub = sv;
        #4;
        check({tag, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_s"}, s, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
        check({tag, "_drained"}, out_valid, 0);
    endtask

    logic [11:0] st_a   [8] = '{12'h123, 12'hFFF, 12'h7FF, 12'h005, 12'h800, 12'h0FF, 12'h100, 12'hABC};
    logic [11:0] st_b   [8] = '{12'h456, 12'h001, 12'h001, 12'h007, 12'h001, 12'h001, 12'h001, 12'h543};
    logic        st_cin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        st_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    // {cout, ovf, s}
    logic [13:0] st_exp [8] = '{{2'b00, 12'h579}, {2'b10, 12'h000}, {2'b01, 12'h800},
                                {2'b00, 12'hFFE}, {2'b11, 12'h7FF}, {2'b00, 12'h101},
                                {2'b10, 12'h0FE}, {2'b00, 12'hFFF}};

    logic [13:0] q [$];
    logic [13:0] exp_r;
    int          in_idx;
    int          out_idx;
    int          stale;
    int          sent;
    int          got;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Directed single operations
        run_op("carry_chain", 12'h0FF, 12'h001, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0);
        run_op("wrap_add",    12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        run_op("pos_ovf",     12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
        run_op("sub_borrow",  12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
        run_op("sub_ovf",     12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);

        // Back-to-back stream with the consumer stalled in cycles 4..7
        in_idx = 0; out_idx = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            in_valid = (in_idx < 8);
            if (in_idx < 8) begin
                a = st_a[in_idx]; b = st_b[in_idx]; cin = st_cin[in_idx]; sub = st_sub[in_idx];
            end
            out_ready = !(cyc >= 4 && cyc <= 7);
            #4;
            if (cyc < 12) begin
                check($sformatf("stream_in_ready_c%0d", cyc), in_ready, (cyc < 4 || cyc >= 8));
            end
            if (cyc >= 4 && cyc <= 7) begin
                check($sformatf("stall_valid_c%0d", cyc), out_valid, 1);
                check($sformatf("stall_hold_c%0d", cyc), {cout, ovf, s}, st_exp[1]);
            end
            if (out_valid && out_ready) begin
                if (out_idx < 8) begin
                    check($sformatf("stream_out%0d", out_idx), {cout, ovf, s}, st_exp[out_idx]);
                end
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_accepted", in_idx, 8);
        check("stream_emitted", out_idx, 8);

        // Asynchronous reset with operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 12'h111 * 12'(i + 3); b = 12'h222; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rst2_pre_valid", out_valid, 1);
        check("rst2_pre_s", s, 12'h555);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_async_valid", out_valid, 0);
        check("rst2_async_s", s, 0);
        check("rst2_async_cout", cout, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        check("rst2_no_stale", stale, 0);
        run_op("post_reset", 12'h555, 12'h2AA, 1'b0, 1'b0, 12'h7FF, 1'b0, 1'b0);

        // Randomised stream with random stalls on both sides
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 800 && got < 60; cyc++) begin
            in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
            a         = 12'($urandom);
            b         = 12'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    exp_r = q.pop_front();
                    check($sformatf("rnd_out%0d", got), {cout, ovf, s}, exp_r);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(a, b, cin, sub));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rnd_sent", sent, 60);
        check("rnd_got", got, 60);
        check("rnd_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
